// File: rtl/uart_pkg.sv
// Shared definitions for the system-bus UART transmitter: register offsets,
// transmitter FSM states and the reset bit-period calculation.
package uart_pkg;

    // Byte offsets of the peripheral registers (only addr[7:0] is decoded)
    localparam logic [7:0] REG_DATA   = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_DIV    = 8'h08;
    localparam logic [7:0] REG_PARITY = 8'h0C;
    localparam logic [7:0] REG_STOP   = 8'h10;
    localparam logic [7:0] REG_RST    = 8'h24;

    // Smallest accepted bit period in clocks; smaller DIV writes are dropped
    localparam logic [15:0] DIV_MIN = 16'd16;

    // Baud rate used until software programs its own divisor
    localparam int unsigned DEFAULT_BAUD = 9600;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Clocks per bit at DEFAULT_BAUD, clamped into the legal 16-bit range
    function automatic logic [15:0] default_div(input int unsigned clk_hz);
        int unsigned d;
        d = clk_hz / DEFAULT_BAUD;
        if (d < 32'(DIV_MIN)) begin
            d = 32'(DIV_MIN);
        end
        if (d > 32'd65535) begin
            d = 32'd65535;
        end
        return d[15:0];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART transmitter. A push into a full
// FIFO is accepted only when a pop happens on the same edge; otherwise it is
// dropped and reported on drop_o so the owner can record an overflow.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign drop_o  = push_i & ~do_push;

    // Storage array: written on every accepted push, never reset
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy 0..DEPTH
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_sb_ctrl.sv
// System-bus UART transmitter: register decode, configuration registers,
// registered read port, TX byte FIFO and the serialising FSM driving tx_o.
module uart_tx_sb_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 10_000_000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        tx_o,
    output logic        busy_o
);

    localparam logic [15:0] DIV_RST = default_div(CLK_FREQ_HZ);
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

    // Bus decode
    logic [7:0] offs;
    logic       wr_sel;
    logic       rd_sel;
    logic       push_req;
    logic       soft_rst;
    logic       unused_bits;

    // Configuration and status
    logic [15:0] div_q;
    logic        par_en_q;
    logic        stop2_q;
    logic        ovf_q;
    logic [31:0] rd_mux;
    logic [31:0] read_data_q;
    logic        busy;

    // FIFO interface
    logic [7:0]       fifo_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_drop;
    logic             fifo_pop;

    // Transmitter FSM state
    tx_state_t   state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shreg_q, shreg_d;
    logic        tx_q, tx_d;
    logic [15:0] cdiv_q, cdiv_d;
    logic        cpar_q, cpar_d;
    logic        cstop2_q, cstop2_d;
    logic        bit_end;
    logic        load;

    assign offs        = addr_i[7:0];
    assign wr_sel      = req_i & write_enable_i;
    assign rd_sel      = req_i & ~write_enable_i;
    assign push_req    = wr_sel & (offs == REG_DATA);
    assign soft_rst    = wr_sel & (offs == REG_RST) & write_data_i[0];
    assign unused_bits = ^{addr_i[31:8], write_data_i[31:16]};

    assign busy        = (fifo_count != '0) | (state_q != ST_IDLE);
    assign busy_o      = busy;
    assign tx_o        = tx_q;
    assign read_data_o = read_data_q;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (soft_rst),
        .push_i  (push_req),
        .data_i  (write_data_i[7:0]),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    // Configuration registers and the sticky overflow flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            div_q    <= DIV_RST;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (soft_rst) begin
            div_q    <= DIV_RST;
            par_en_q <= 1'b0;
            stop2_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_sel) begin
                case (offs)
                    REG_STATUS: ovf_q <= 1'b0;
                    REG_DIV: begin
                        if (write_data_i[15:0] >= DIV_MIN) begin
                            div_q <= write_data_i[15:0];
                        end
                    end
                    REG_PARITY: par_en_q <= write_data_i[0];
                    REG_STOP:   stop2_q  <= write_data_i[0];
                    default:    ;
                endcase
            end
            if (fifo_drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Read data selection for the addressed register
    always_comb begin
        rd_mux = '0;
        case (offs)
            REG_STATUS: rd_mux = {29'b0, ovf_q, fifo_full, busy};
            REG_DIV:    rd_mux = {16'b0, div_q};
            REG_PARITY: rd_mux = {31'b0, par_en_q};
            REG_STOP:   rd_mux = {31'b0, stop2_q};
            default:    rd_mux = '0;
        endcase
    end

    // Read port: captured on a read strobe, held otherwise; soft reset leaves it alone
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            read_data_q <= '0;
        end else if (rd_sel) begin
            read_data_q <= rd_mux;
        end
    end

    assign bit_end = (baud_q == '0);

    // Next-state logic: every non-idle state spans cdiv clocks, config frozen per frame
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        tx_d     = tx_q;
        cdiv_d   = cdiv_q;
        cpar_d   = cpar_q;
        cstop2_d = cstop2_q;
        fifo_pop = 1'b0;
        load     = 1'b0;

        if (state_q != ST_IDLE) begin
            if (bit_end) begin
                baud_d = cdiv_q - 16'd1;
            end else begin
                baud_d = baud_q - 16'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    load = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q != 3'd7) begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shreg_q[bit_q + 3'd1];
                    end else if (cpar_q) begin
                        state_d = ST_PARITY;
                        tx_d    = ^shreg_q;
                    end else begin
                        state_d = ST_STOP;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (cstop2_q && (bit_q == 3'd0)) begin
                        bit_d = 3'd1;
                    end else if (!fifo_empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        if (load) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_data;
            cdiv_d   = div_q;
            cpar_d   = par_en_q;
            cstop2_d = stop2_q;
            baud_d   = div_q - 16'd1;
            bit_d    = 3'd0;
            state_d  = ST_START;
            tx_d     = 1'b0;
        end
    end

    // FSM registers; either reset aborts a frame and returns the line high
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            cdiv_q   <= DIV_RST;
            cpar_q   <= 1'b0;
            cstop2_q <= 1'b0;
        end else if (soft_rst) begin
            state_q  <= ST_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            tx_q     <= 1'b1;
            cdiv_q   <= DIV_RST;
            cpar_q   <= 1'b0;
            cstop2_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            tx_q     <= tx_d;
            cdiv_q   <= cdiv_d;
            cpar_q   <= cpar_d;
            cstop2_q <= cstop2_d;
        end
    end

endmodule
